deserializer: RTL and testbench



---
 rtl/deser_pkg.sv | 21 ++
 rtl/deser_fifo2.sv | 67 ++++++
 rtl/deserializer.sv | 100 ++++++++++
 tb/tb_deserializer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared types and helpers for the serial-to-parallel receiver.
package deser_pkg;

   // Receiver FSM: waiting for a word, or capturing bits of a word.
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 4;

   // Width of a counter that indexes bit positions 0..n-1 (at least 1 bit).
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/deser_fifo2.sv
// Two-entry output buffer with a registered head word.
// Push and pop may happen on the same edge, including when full.
module deser_fifo2 #(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              vld,
   output logic              full
);

   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] tail;
   logic [1:0]        occ;
   logic [1:0]        occ_nxt;
   logic              pop_eff;
   logic              push_eff;

   // A pop of an empty buffer is ignored; a push into a full buffer only
   // lands when the head leaves on the same edge.
   assign pop_eff  = pop & vld;
   assign push_eff = push & (~full | pop_eff);
   assign dout     = head;

   // Next occupancy from the accepted push/pop pair.
   always_comb begin
      // NOTE: assign a default before any branch so no path leaves occ_nxt unassigned (which would infer a latch).
      occ_nxt = occ;
      if (push_eff && !pop_eff)
         occ_nxt = occ + 2'd1;
      else if (pop_eff && !push_eff)
         occ_nxt = occ - 2'd1;
   end

   // Storage update; head always holds the oldest word.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the two data slots are reset too, so the visible head reads 0 after reset rather than stale data.
         head <= '0;
         tail <= '0;
         occ  <= 2'd0;
         vld  <= 1'b0;
         full <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so every register here samples pre-edge values.
         if (pop_eff) begin
            if (occ == 2'd2) begin
               head <= tail;
               if (push_eff) tail <= din;
            end else if (push_eff) begin
               head <= din;
            end
         end else if (push_eff) begin
            if (occ == 2'd0) head <= din;
            else             tail <= din;
         end
         occ  <= occ_nxt;
         vld  <= (occ_nxt != 2'd0);
         full <= (occ_nxt == 2'd2);
      end
   end

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: reassembles LSB-first bit streams into
// DATA_W-bit words, buffers them, and flags truncation and overflow.
module deserializer
   import deser_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              srl_in,
   input  logic              srl_vld,
   output logic              srl_rdy,
   output logic [DATA_W-1:0] pll_out,
   output logic              pll_vld,
   input  logic              pll_rdy,
   output logic              frm_err,
   output logic              ovf
);

   localparam int CNT_W = clog2(DATA_W);

   if (DATA_W < 2) begin : g_bad_width
      $error("deserializer: DATA_W must be at least 2");
   end
   if (FIFO_DEPTH != 2) begin : g_bad_depth
      $error("deserializer: only FIFO_DEPTH=2 is supported");
   end

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] word_asm;
   logic              last_bit;
   logic              word_done;
   logic              pop;
   logic              fifo_full;

   // Shift register with the incoming bit merged at position cnt; in IDLE
   // cnt is 0, so the first bit of a word lands in bit 0.
   always_comb begin
      word_asm      = shreg;
      word_asm[cnt] = srl_in;
   end

   assign last_bit  = (cnt == CNT_W'(DATA_W - 1));
   assign word_done = srl_vld && (state == SHIFT) && last_bit;
   assign pop       = pll_vld & pll_rdy;
   assign srl_rdy   = ~fifo_full;

   // Capture FSM, bit counter, truncation pulse and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         shreg   <= '0;
         frm_err <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         frm_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (srl_vld) begin
                  shreg <= word_asm;
                  cnt   <= CNT_W'(1);
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (srl_vld) begin
                  shreg <= word_asm;
                  cnt   <= last_bit ? '0 : cnt + CNT_W'(1);
               end else begin
                  // A gap mid-word means the word was cut short.
                  if (cnt != '0) frm_err <= 1'b1;
                  cnt   <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         // Completed word with nowhere to go is dropped.
         if (word_done && fifo_full && !pop) ovf <= 1'b1;
      end
   end

   deser_fifo2 #(
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (word_done),
      .din  (word_asm),
      .pop  (pop),
      .dout (pll_out),
      .vld  (pll_vld),
      .full (fifo_full)
   );

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for the deserializer: a queue-based word model predicts
// output words, frm_err and ovf; a negedge monitor compares every cycle.
module tb_deserializer;

   localparam int DATA_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              srl_in;
   logic              srl_vld;
   logic              srl_rdy;
   logic [DATA_W-1:0] pll_out;
   logic              pll_vld;
   logic              pll_rdy;
   logic              frm_err;
   logic              ovf;

   always #5 clk = ~clk;

   deserializer #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .srl_in  (srl_in),
      .srl_vld (srl_vld),
      .srl_rdy (srl_rdy),
      .pll_out (pll_out),
      .pll_vld (pll_vld),
      .pll_rdy (pll_rdy),
      .frm_err (frm_err),
      .ovf     (ovf)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Scoreboard: words the consumer should see, oldest first (max 2 held).
   int q[$];
   int exp_frm = 0;
   int exp_ovf = 0;
   bit mon_en  = 1'b0;

   // Model of the word being received.
   int m_cnt = 0;
   int m_val = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, predict its effect, and commit the
   // prediction at the clock edge.
   task automatic step(input logic v, input logic b, input logic rdy, input logic r);
      bit p_push;
      int p_word;
      int p_frm;
      bit p_ovf;
      srl_vld = v;
      srl_in  = b;
      pll_rdy = rdy;
      rst     = r;
      p_push  = 1'b0;
      p_word  = 0;
      p_frm   = 0;
      p_ovf   = 1'b0;
      if (r) begin
         m_cnt = 0;
         m_val = 0;
      end else if (v) begin
         m_val = m_val | (int'(b) << m_cnt);
         m_cnt++;
         if (m_cnt == DATA_W) begin
            // Room exists if not full, or if the head leaves this edge.
            if (q.size() < 2 || rdy) begin
               p_push = 1'b1;
               p_word = m_val;
            end else begin
               p_ovf = 1'b1;
            end
            m_cnt = 0;
            m_val = 0;
         end
      end else begin
         if (m_cnt != 0) p_frm = 1;
         m_cnt = 0;
         m_val = 0;
      end
      @(posedge clk);
      if (r) begin
         q.delete();
         exp_ovf = 0;
         mon_en  = 1'b1;
      end else begin
         if (p_push) q.push_back(p_word);
         if (p_ovf) exp_ovf = 1;
      end
      exp_frm = p_frm;
      #1;
   endtask

   task automatic send_word(input logic [DATA_W-1:0] w, input logic rdy);
      for (int i = 0; i < DATA_W; i++) step(1'b1, w[i], rdy, 1'b0);
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, rdy, 1'b0);
   endtask

   // Monitor: compare DUT outputs with the scoreboard away from the edge.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("pll_vld", int'(pll_vld), int'(q.size() != 0));
            if (q.size() != 0 && pll_vld) check("pll_out", int'(pll_out), q[0]);
            check("srl_rdy", int'(srl_rdy), int'(q.size() < 2));
            check("frm_err", int'(frm_err), exp_frm);
            check("ovf", int'(ovf), exp_ovf);
            if (q.size() != 0 && pll_rdy) void'(q.pop_front());
         end
      end
   end

   initial begin
      logic [DATA_W-1:0] w7;
      w7 = 4'h7;

      // Reset state.
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("reset pll_out", int'(pll_out), 0);
      idle(2, 1'b1);

      // Single word 0xA (bits 0,1,0,1).
      send_word(4'hA, 1'b1);
      idle(3, 1'b1);

      // Back-to-back 0xF then 0xC.
      send_word(4'hF, 1'b1);
      send_word(4'hC, 1'b1);
      idle(3, 1'b1);

      // Backpressure and overflow: third word dropped, ovf sticky.
      send_word(4'h3, 1'b0);
      send_word(4'h5, 1'b0);
      idle(1, 1'b0);
      send_word(4'h9, 1'b0);
      idle(2, 1'b0);
      idle(4, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      idle(1, 1'b1);

      // Full buffer with pop on the edge the third word completes.
      send_word(4'h1, 1'b0);
      send_word(4'h2, 1'b0);
      for (int i = 0; i < DATA_W; i++)
         step(1'b1, w7[i], (i == DATA_W - 1), 1'b0);
      idle(4, 1'b1);

      // Truncated word, then a good word 0x6.
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      idle(3, 1'b1);
      send_word(4'h6, 1'b1);
      idle(3, 1'b1);

      // Reset mid-word, then word 0xB.
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("mid-word reset pll_out", int'(pll_out), 0);
      idle(1, 1'b1);
      send_word(4'hB, 1'b1);
      idle(3, 1'b1);

      // Randomized traffic: gaps, truncations, backpressure, rare resets.
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 199) == 0));
      idle(4, 1'b1);

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
